ascon_ti_share_codec: RTL

Boundary block for the 3-share threshold-implementation Ascon datapath. In mask mode it splits a plain 320-bit Ascon state into three Boolean shares, using an internal xorshift64 PRNG, before the state enters the shared permutation. In unmask mode it recombines three shares into the plain state at the exit of the shared permutation. It forms the encoder/decoder pair around the TI substitution layer.

---
 rtl/ascon_ti_share_codec.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ascon_ti_share_codec.sv
// Boundary codec for the 3-share TI Ascon datapath: masks a plain 320-bit state
// into three Boolean shares via an xorshift64 PRNG, or recombines three shares.
module ascon_ti_share_codec (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_valid,
    input  logic [63:0]  seed,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [319:0] in_s0,
    input  logic [319:0] in_s1,
    input  logic [319:0] in_s2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_s0,
    output logic [319:0] out_s1,
    output logic [319:0] out_s2,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, LATCH, GEN, OUT} state_t;

    localparam logic [63:0] PRNG_INIT = 64'h0123_4567_89AB_CDEF;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [63:0]    prng_q;
    logic           mode_q;
    logic [319:0]   plain_q;
    logic [319:0]   outS0_q;
    logic [319:0]   outS1_q;
    logic [319:0]   outS2_q;

    logic [63:0]    stepA_d;
    logic [63:0]    stepB_d;
    logic [63:0]    prngStep_d;
    logic [319:0]   share1_d;
    logic [319:0]   share2_d;

    always_comb begin
        stepA_d    = prng_q ^ (prng_q << 13);
        stepB_d    = stepA_d ^ (stepA_d >> 7);
        prngStep_d = stepB_d ^ (stepB_d << 17);
    end

    // Word k lands in share-1 lane k (k < 5) or share-2 lane k-5; lane 0 is the top 64 bits.
    always_comb begin
        share1_d = outS1_q;
        share2_d = outS2_q;
        for (int k = 0; k < 5; k++) begin
            if (cnt_q == 4'(k))
                share1_d[319-64*k -: 64] = prngStep_d;
            if (cnt_q == 4'(k + 5))
                share2_d[319-64*k -: 64] = prngStep_d;
        end
    end

    // Share registers double as the input holding registers between IDLE and LATCH,
    // so unmask inputs need no extra storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            prng_q  <= PRNG_INIT;
            mode_q  <= 1'b0;
            plain_q <= '0;
            outS0_q <= '0;
            outS1_q <= '0;
            outS2_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seed_valid) begin
                        prng_q <= (seed == 64'd0) ? PRNG_INIT : seed;
                    end else if (in_valid) begin
                        plain_q <= in_s0;
                        outS1_q <= in_s1;
                        outS2_q <= in_s2;
                        mode_q  <= in_mode;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (mode_q) begin
                        outS0_q <= plain_q ^ outS1_q ^ outS2_q;
                        outS1_q <= '0;
                        outS2_q <= '0;
                        state_q <= OUT;
                    end else begin
                        cnt_q   <= 4'd0;
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    prng_q  <= prngStep_d;
                    outS1_q <= share1_d;
                    outS2_q <= share2_d;
                    if (cnt_q == 4'd9) begin
                        outS0_q <= plain_q ^ share1_d ^ share2_d;
                        cnt_q   <= 4'd0;
                        state_q <= OUT;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !seed_valid;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_s0    = outS0_q;
    assign out_s1    = outS1_q;
    assign out_s2    = outS2_q;

endmodule
